api_sched: RTL and testbench

API_SCHED -- requirements
Module: api_sched

---
 rtl/api_sched.sv | 176 +++++++++++++++++
 tb/tb_api_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/api_sched.sv
// Hash-chain work scheduler: round-robins enabled chains, streams work
// words out over the PHY link and tags returned nonce blocks into the RX FIFO.
module api_sched #(
  parameter int API_NUM        = 10,
  parameter int RX_FIFO_DEPTH  = 512,
  parameter int RX_BLOCK_LEN   = 11,
  parameter int WORK_LEN       = 23,
  parameter int MAX_CHIP_IN_CH = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           reg_rst,
  input  logic [API_NUM-1:0]             reg_ch_en,
  input  logic [7:0]                     reg_word_num,
  input  logic [27:0]                    reg_timeout,
  input  logic                           tx_fifo_empty,
  output logic                           tx_fifo_rd_en,
  input  logic [31:0]                    tx_fifo_dout,
  output logic                           rx_fifo_wr_en,
  output logic [31:0]                    rx_fifo_din,
  input  logic [$clog2(RX_FIFO_DEPTH):0] rx_fifo_data_count,
  output logic                           phy_mosi_vld,
  output logic [31:0]                    phy_mosi_dat,
  input  logic                           phy_miso_vld,
  input  logic [31:0]                    phy_miso_dat,
  output logic                           phy_miso,
  output logic [API_NUM-1:0]             load,
  input  logic [API_NUM-1:0]             miso,
  output logic [4:0]                     chain_id,
  output logic                           nonce_hit,
  output logic [4:0]                     nonce_id,
  output logic [2:0]                     reg_state,
  output logic                           timeout_busy
);

  localparam int BW = $clog2(WORK_LEN);
  localparam int IW = (API_NUM > 2) ? $clog2(API_NUM) : 1;
  localparam int SPACE_LIM = RX_FIFO_DEPTH - RX_BLOCK_LEN * MAX_CHIP_IN_CH;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_SEL  = 2'd1,
    S_WORK = 2'd2,
    S_NOP  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [API_NUM-1:0] r_load;
  logic [API_NUM-1:0] w_load_sel;
  logic [API_NUM-1:0] w_load_rot;
  logic [7:0]         r_word_cnt;
  logic [BW-1:0]      r_blk_cnt;
  logic [27:0]        r_timer;
  logic [3:0]         r_nop_cnt;
  logic               r_mosi_vld;
  logic               r_nonce_hit;
  logic [4:0]         r_nonce_id;
  logic [4:0]         w_chain_id;
  logic [5:0]         w_idx;
  logic               w_srst;
  logic               w_start;
  logic               w_work;
  logic               w_acc;
  logic               w_wr;
  logic               w_more;
  logic               w_hit;

  assign w_srst  = rst | reg_rst;
  assign w_work  = (r_state == S_WORK);
  assign w_acc   = phy_miso_vld & w_work;
  assign w_wr    = w_acc & (r_blk_cnt < BW'(RX_BLOCK_LEN));
  assign w_more  = ({1'b0, r_word_cnt} + 9'd1) < {1'b0, reg_word_num};
  assign w_hit   = w_wr & (r_blk_cnt == BW'(RX_BLOCK_LEN - 2))
                 & (phy_miso_dat == 32'hbeafbeaf);
  assign w_start = (r_timer == '0) & ~tx_fifo_empty
                 & (|reg_ch_en) & (|reg_word_num)
                 & (int'(rx_fifo_data_count) <= SPACE_LIM);

  always_comb begin
    w_chain_id = '0;
    for (int i = 0; i < API_NUM; i++)
      if (!r_load[i]) w_chain_id = 5'(i);
  end

  // Descending offset scan: the last hit wins, i.e. the nearest enabled chain.
  always_comb begin
    w_load_sel = r_load;
    w_load_rot = r_load;
    w_idx      = '0;
    for (int k = API_NUM - 1; k >= 0; k--) begin
      w_idx = {1'b0, w_chain_id} + 6'(k);
      if (w_idx >= 6'(API_NUM)) w_idx = w_idx - 6'(API_NUM);
      if (reg_ch_en[w_idx[IW-1:0]]) begin
        w_load_sel = ~(API_NUM'(1) << w_idx);
        if (k != 0) w_load_rot = ~(API_NUM'(1) << w_idx);
      end
    end
    if (reg_ch_en[w_chain_id[IW-1:0]]) w_load_sel = r_load;
  end

  always_ff @(posedge clk) begin
    if (w_srst) r_state <= S_WAIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT: if (w_start) w_next = S_SEL;
      S_SEL:  w_next = S_WORK;
      S_WORK: if (r_word_cnt == reg_word_num) w_next = S_NOP;
      S_NOP:  if (r_nop_cnt == 4'd14) w_next = S_WAIT;
      default: w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_srst) begin
      r_load      <= {API_NUM{1'b1}} ^ API_NUM'(1);
      r_word_cnt  <= '0;
      r_blk_cnt   <= '0;
      r_timer     <= '0;
      r_nop_cnt   <= '0;
      r_mosi_vld  <= 1'b0;
      r_nonce_hit <= 1'b0;
      r_nonce_id  <= '0;
    end else begin
      r_mosi_vld  <= 1'b0;
      r_nonce_hit <= w_hit;
      if (w_hit) r_nonce_id <= w_chain_id;
      if (r_timer != '0) r_timer <= r_timer - 28'd1;
      unique case (r_state)
        S_SEL: begin
          r_load     <= w_load_sel;
          r_word_cnt <= '0;
          r_blk_cnt  <= '0;
          r_timer    <= reg_timeout;
          r_mosi_vld <= 1'b1;
        end
        S_WORK: begin
          r_nop_cnt <= '0;
          if (w_acc) begin
            r_word_cnt <= r_word_cnt + 8'd1;
            r_blk_cnt  <= (r_blk_cnt == BW'(WORK_LEN - 1)) ? '0
                        : r_blk_cnt + BW'(1);
            r_mosi_vld <= w_more;
          end
        end
        S_NOP: begin
          r_nop_cnt <= r_nop_cnt + 4'd1;
          if (r_nop_cnt == 4'd14) r_load <= w_load_rot;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_fifo_rd_en = r_mosi_vld & w_work;
    phy_mosi_vld  = r_mosi_vld;
    phy_mosi_dat  = tx_fifo_dout;
    rx_fifo_wr_en = w_wr;
    rx_fifo_din   = phy_miso_dat;
    if (r_blk_cnt == BW'(RX_BLOCK_LEN - 1))
      rx_fifo_din = {phy_miso_dat[31:16], 8'h12, 3'b000, w_chain_id};
    phy_miso      = &(miso | r_load);
    load          = r_load;
    chain_id      = w_chain_id;
    nonce_hit     = r_nonce_hit;
    nonce_id      = r_nonce_id;
    reg_state     = {1'b0, r_state};
    timeout_busy  = (r_timer != '0);
  end

endmodule

// File: tb/tb_api_sched.sv
// Directed bench for api_sched: a PHY echo responder plus hand-computed
// expectations for rotation, FIFO gating, timeout, nonce tagging and soft reset.
module tb_api_sched;

  logic        clk = 1'b0;
  logic        rst, reg_rst;
  logic [9:0]  reg_ch_en;
  logic [7:0]  reg_word_num;
  logic [27:0] reg_timeout;
  logic        tx_fifo_empty, tx_fifo_rd_en;
  logic [31:0] tx_fifo_dout;
  logic        rx_fifo_wr_en;
  logic [31:0] rx_fifo_din;
  logic [9:0]  rx_fifo_data_count;
  logic        phy_mosi_vld;
  logic [31:0] phy_mosi_dat;
  logic        phy_miso_vld;
  logic [31:0] phy_miso_dat;
  logic        phy_miso;
  logic [9:0]  load, miso;
  logic [4:0]  chain_id, nonce_id;
  logic        nonce_hit, timeout_busy;
  logic [2:0]  reg_state;

  logic        resp_vld, stray, nonce_on;
  int          wi;

  int          n_chk, n_err, cyc;
  int          n_rd, n_wr, n_hit, n_nop, n_sel;
  logic [31:0] tagw;
  logic [4:0]  hit_id;
  logic [2:0]  prev_st, max_st;
  int          ws_cyc[$];
  logic [4:0]  ws_ch[$];
  int          diff;

  always #5 clk = ~clk;

  assign phy_miso_vld = resp_vld | stray;

  api_sched dut (
    .clk(clk), .rst(rst), .reg_rst(reg_rst),
    .reg_ch_en(reg_ch_en), .reg_word_num(reg_word_num),
    .reg_timeout(reg_timeout),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_rd_en(tx_fifo_rd_en),
    .tx_fifo_dout(tx_fifo_dout),
    .rx_fifo_wr_en(rx_fifo_wr_en), .rx_fifo_din(rx_fifo_din),
    .rx_fifo_data_count(rx_fifo_data_count),
    .phy_mosi_vld(phy_mosi_vld), .phy_mosi_dat(phy_mosi_dat),
    .phy_miso_vld(phy_miso_vld), .phy_miso_dat(phy_miso_dat),
    .phy_miso(phy_miso), .load(load), .miso(miso),
    .chain_id(chain_id), .nonce_hit(nonce_hit), .nonce_id(nonce_id),
    .reg_state(reg_state), .timeout_busy(timeout_busy)
  );

  // Echoes each MOSI word back one cycle later; word 9 optionally a nonce.
  initial begin
    resp_vld     = 1'b0;
    phy_miso_dat = '0;
    wi           = 0;
    forever begin
      @(negedge clk);
      if (reg_state != 3'd2) wi = 0;
      resp_vld = phy_mosi_vld;
      if (phy_mosi_vld) begin
        phy_miso_dat = (nonce_on && wi == 9) ? 32'hbeafbeaf
                     : 32'h1000_0000 + wi;
        wi++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_rd = 0; n_wr = 0; n_hit = 0; n_nop = 0; n_sel = 0;
    tagw = '0; hit_id = '0; max_st = '0;
    ws_cyc.delete(); ws_ch.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (tx_fifo_rd_en) n_rd++;
    if (rx_fifo_wr_en) begin
      if (n_wr == 10) tagw = rx_fifo_din;
      n_wr++;
    end
    if (nonce_hit) begin n_hit++; hit_id = nonce_id; end
    if (reg_state == 3'd3) n_nop++;
    if (reg_state == 3'd1) n_sel++;
    if (reg_state == 3'd2 && prev_st == 3'd1) begin
      ws_cyc.push_back(cyc);
      ws_ch.push_back(chain_id);
    end
    if (reg_state > max_st) max_st = reg_state;
    prev_st = reg_state;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    clr();
  endtask

  task automatic run_one(input string tag);
    bit seen_nop = 0;
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (reg_state == 3'd3) seen_nop = 1;
      if (seen_nop && reg_state == 3'd0) done = 1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; prev_st = '0;
    rst = 1'b1; reg_rst = 1'b0; stray = 1'b0; nonce_on = 1'b0;
    reg_ch_en = 10'h3FF; reg_word_num = 8'd23; reg_timeout = '0;
    tx_fifo_empty = 1'b1; tx_fifo_dout = 32'hCAFE0001;
    rx_fifo_data_count = '0; miso = 10'h3FE;
    clr();
    do_reset();

    check("rst_state", 32'(reg_state), 32'd0);
    check("rst_load", 32'(load), 32'h3FE);
    check("rst_chain_id", 32'(chain_id), 32'd0);
    check("rst_busy", 32'(timeout_busy), 32'd0);
    check("rst_mosi_vld", 32'(phy_mosi_vld), 32'd0);
    check("rst_hit", 32'(nonce_hit), 32'd0);
    check("phy_miso_sel_low", 32'(phy_miso), 32'd0);
    miso = 10'h3FD; #1;
    check("phy_miso_masked", 32'(phy_miso), 32'd1);
    miso = 10'h3FF; #1;
    check("phy_miso_high", 32'(phy_miso), 32'd1);
    check("mosi_dat", phy_mosi_dat, 32'hCAFE0001);

    // Full 23-word transaction on chain 0
    tx_fifo_empty = 1'b0;
    run_one("t1");
    tx_fifo_empty = 1'b1;
    check("t1_rd", 32'(n_rd), 32'd23);
    check("t1_wr", 32'(n_wr), 32'd11);
    check("t1_tag", tagw, 32'h1000_1200);
    check("t1_nop", 32'(n_nop), 32'd15);
    check("t1_work_ch", 32'(ws_ch.size() > 0 ? ws_ch[0] : 5'd31), 32'd0);
    check("t1_load_next", 32'(load), 32'h3FD);
    check("t1_chain_next", 32'(chain_id), 32'd1);
    check("t1_no_hit", 32'(n_hit), 32'd0);

    // Sparse mask rotation
    do_reset();
    reg_ch_en = 10'b0000100101;
    tx_fifo_empty = 1'b0;
    for (int k = 0; k < 4; k++) run_one("t2");
    tx_fifo_empty = 1'b1;
    check("t2_n", 32'(ws_ch.size()), 32'd4);
    check("t2_c0", 32'(ws_ch.size() > 0 ? ws_ch[0] : 5'd31), 32'd0);
    check("t2_c1", 32'(ws_ch.size() > 1 ? ws_ch[1] : 5'd31), 32'd2);
    check("t2_c2", 32'(ws_ch.size() > 2 ? ws_ch[2] : 5'd31), 32'd5);
    check("t2_c3", 32'(ws_ch.size() > 3 ? ws_ch[3] : 5'd31), 32'd0);

    // RX FIFO free-space gate
    do_reset();
    reg_ch_en = 10'h3FF;
    rx_fifo_data_count = 10'd458;
    tx_fifo_empty = 1'b0;
    repeat (10) tick();
    check("t3_458_wait", 32'(max_st), 32'd0);
    rx_fifo_data_count = 10'd457;
    clr();
    repeat (2) tick();
    check("t3_457_sel", 32'(n_sel), 32'd1);
    run_one("t3");
    tx_fifo_empty = 1'b1;
    rx_fifo_data_count = '0;

    // Timeout spacing
    do_reset();
    reg_timeout = 28'd100;
    tx_fifo_empty = 1'b0;
    run_one("t4a");
    check("t4_busy", 32'(timeout_busy), 32'd1);
    run_one("t4b");
    tx_fifo_empty = 1'b1;
    reg_timeout = '0;
    diff = (ws_cyc.size() > 1) ? ws_cyc[1] - ws_cyc[0] : 0;
    check("t4_gap_min", 32'(diff >= 100), 32'd1);
    check("t4_gap_max", 32'(diff <= 104), 32'd1);

    // Nonce on chain 7
    do_reset();
    reg_ch_en = 10'b0010000000;
    nonce_on = 1'b1;
    tx_fifo_empty = 1'b0;
    run_one("t5a");
    check("t5_ch", 32'(ws_ch.size() > 0 ? ws_ch[0] : 5'd31), 32'd7);
    check("t5_hits", 32'(n_hit), 32'd1);
    check("t5_id", 32'(hit_id), 32'd7);
    nonce_on = 1'b0;
    clr();
    run_one("t5b");
    tx_fifo_empty = 1'b1;
    check("t5_nohit", 32'(n_hit), 32'd0);
    check("t5_load_stay", 32'(load), 32'h37F);

    // Soft reset mid-WORK
    do_reset();
    reg_ch_en = 10'h3FF;
    tx_fifo_empty = 1'b0;
    run_one("t6a");
    clr();
    for (int i = 0; i < 100 && n_rd < 5; i++) tick();
    check("t6_reached_w5", 32'(n_rd), 32'd5);
    reg_rst = 1'b1;
    tx_fifo_empty = 1'b1;
    tick();
    reg_rst = 1'b0;
    check("t6_state", 32'(reg_state), 32'd0);
    check("t6_load", 32'(load), 32'h3FE);
    clr();
    repeat (30) tick();
    check("t6_no_rd", 32'(n_rd), 32'd0);
    check("t6_no_wr", 32'(n_wr), 32'd0);

    // Stray MISO outside WORK
    stray = 1'b1; #1;
    check("stray_no_wr", 32'(rx_fifo_wr_en), 32'd0);
    tick();
    stray = 1'b0;
    check("stray_state", 32'(reg_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
